// File: rtl/can_mem_arb_pkg.sv
// Shared types and defaults for the CAN frame-RAM arbiter.
package can_mem_arb_pkg;

    localparam int unsigned ADDR_W = 10;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned BE_W   = DATA_W / 8;

    typedef enum logic [1:0] {
        OPEN  = 2'd0,
        LOCK0 = 2'd1,
        LOCK1 = 2'd2
    } arb_state_t;

    localparam logic P_CAN  = 1'b0;
    localparam logic P_HOST = 1'b1;

endpackage

// File: rtl/can_rr_arb2.sv
// Two-way round-robin picker: masked requests, tie goes to the port that did not win last.
module can_rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic [1:0] lock_mask,
    output logic [1:0] grant
);

    logic [1:0] eff_req;

    // One-hot grant from the unmasked requests
    always_comb begin
        eff_req = req & ~lock_mask;
        grant   = 2'b00;
        if (eff_req == 2'b11) begin
            grant = last ? 2'b01 : 2'b10;
        end else begin
            grant = eff_req;
        end
    end

endmodule

// File: rtl/can_mem_arbiter.sv
// Shares the single-port frame RAM between the CAN frame engine (port 0) and the host (port 1).
module can_mem_arbiter #(
    parameter int unsigned MAX_LOCK = 4,
    parameter int unsigned ADDR_W   = can_mem_arb_pkg::ADDR_W,
    parameter int unsigned DATA_W   = can_mem_arb_pkg::DATA_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  p0_valid,
    input  logic                  p0_write,
    input  logic [ADDR_W-1:0]     p0_address,
    input  logic [DATA_W/8-1:0]   p0_byteenable,
    input  logic [DATA_W-1:0]     p0_writedata,
    input  logic                  p0_lock,
    output logic                  p0_ready,
    output logic [DATA_W-1:0]     p0_readdata,
    output logic                  p0_readdatavalid,
    input  logic                  p1_valid,
    input  logic                  p1_write,
    input  logic [ADDR_W-1:0]     p1_address,
    input  logic [DATA_W/8-1:0]   p1_byteenable,
    input  logic [DATA_W-1:0]     p1_writedata,
    input  logic                  p1_lock,
    output logic                  p1_ready,
    output logic [DATA_W-1:0]     p1_readdata,
    output logic                  p1_readdatavalid,
    output logic                  mem_chipselect,
    output logic                  mem_write,
    output logic [ADDR_W-1:0]     mem_address,
    output logic [DATA_W/8-1:0]   mem_byteenable,
    output logic [DATA_W-1:0]     mem_writedata,
    output logic                  mem_clken,
    input  logic [DATA_W-1:0]     mem_readdata
);

    import can_mem_arb_pkg::*;

    localparam int unsigned CNT_W = $clog2(MAX_LOCK + 1);

    arb_state_t       state, state_d;
    logic [CNT_W-1:0] lock_cnt, lock_cnt_d;
    logic             last, rd_pend, rd_id;
    logic [1:0]       req, lock_mask, grant;
    logic             any_grant, win_id, win_write, win_lock, owner;

    // Nobody can be granted while reset is high
    assign req       = {p1_valid, p0_valid} & {2{~reset}};
    assign any_grant = |grant;
    assign win_id    = grant[P_HOST];
    assign win_write = win_id ? p1_write : p0_write;
    assign win_lock  = win_id ? p1_lock : p0_lock;
    assign owner     = (state == LOCK1) ? P_HOST : P_CAN;

    can_rr_arb2 u_rr (
        .req       (req),
        .last      (last),
        .lock_mask (lock_mask),
        .grant     (grant)
    );

    // State, lock counter, round-robin pointer and read-return tracking
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= OPEN;
            lock_cnt <= '0;
            last     <= P_HOST;
            rd_pend  <= 1'b0;
            rd_id    <= P_CAN;
        end else begin
            state    <= state_d;
            lock_cnt <= lock_cnt_d;
            if (any_grant) begin
                last <= win_id;
            end
            rd_pend <= any_grant & ~win_write;
            if (any_grant) begin
                rd_id <= win_id;
            end
        end
    end

    // Next state: enter a lock on a locked grant, hold it for at most MAX_LOCK grants
    always_comb begin
        state_d    = state;
        lock_cnt_d = lock_cnt;
        case (state)
            OPEN: begin
                lock_cnt_d = '0;
                if (any_grant && win_lock && (MAX_LOCK > 1)) begin
                    state_d    = win_id ? LOCK1 : LOCK0;
                    lock_cnt_d = CNT_W'(1);
                end
            end
            LOCK0, LOCK1: begin
                if (any_grant && (win_id == owner) && win_lock &&
                    ((int'(lock_cnt) + 1) < int'(MAX_LOCK))) begin
                    lock_cnt_d = lock_cnt + CNT_W'(1);
                end else begin
                    state_d    = OPEN;
                    lock_cnt_d = '0;
                end
            end
            default: begin
                state_d    = OPEN;
                lock_cnt_d = '0;
            end
        endcase
    end

    // Outputs of the FSM: the locked owner blocks the other port only while it is requesting
    always_comb begin
        lock_mask = 2'b00;
        case (state)
            LOCK0:   lock_mask[P_HOST] = p0_valid;
            LOCK1:   lock_mask[P_CAN]  = p1_valid;
            default: lock_mask = 2'b00;
        endcase
    end

    assign p0_ready = grant[P_CAN];
    assign p1_ready = grant[P_HOST];

    assign mem_clken      = 1'b1;
    assign mem_chipselect = any_grant;
    assign mem_write      = any_grant & win_write;
    assign mem_address    = win_id ? p1_address    : p0_address;
    assign mem_byteenable = win_id ? p1_byteenable : p0_byteenable;
    assign mem_writedata  = win_id ? p1_writedata  : p0_writedata;

    // A read pending across a reset edge is dropped
    assign p0_readdata      = mem_readdata;
    assign p1_readdata      = mem_readdata;
    assign p0_readdatavalid = rd_pend & (rd_id == P_CAN)  & ~reset;
    assign p1_readdatavalid = rd_pend & (rd_id == P_HOST) & ~reset;

endmodule

// File: tb/tb_can_mem_arbiter.sv
// Self-checking bench for can_mem_arbiter with a behavioural RAM and arbitration model.
module tb_can_mem_arbiter;

    localparam int unsigned MAX_LOCK = 4;
    localparam int unsigned ADDR_W   = 10;
    localparam int unsigned DATA_W   = 32;
    localparam int unsigned BE_W     = DATA_W / 8;

    logic clk = 1'b0;
    logic reset;
    logic p0_valid, p0_write, p0_lock, p1_valid, p1_write, p1_lock;
    logic [ADDR_W-1:0] p0_address, p1_address;
    logic [BE_W-1:0]   p0_byteenable, p1_byteenable;
    logic [DATA_W-1:0] p0_writedata, p1_writedata;
    logic p0_ready, p1_ready, p0_readdatavalid, p1_readdatavalid;
    logic [DATA_W-1:0] p0_readdata, p1_readdata;
    logic mem_chipselect, mem_write, mem_clken;
    logic [ADDR_W-1:0] mem_address;
    logic [BE_W-1:0]   mem_byteenable;
    logic [DATA_W-1:0] mem_writedata, mem_readdata;

    always #5 clk = ~clk;

    can_mem_arbiter #(
        .MAX_LOCK (MAX_LOCK),
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .p0_valid         (p0_valid),
        .p0_write         (p0_write),
        .p0_address       (p0_address),
        .p0_byteenable    (p0_byteenable),
        .p0_writedata     (p0_writedata),
        .p0_lock          (p0_lock),
        .p0_ready         (p0_ready),
        .p0_readdata      (p0_readdata),
        .p0_readdatavalid (p0_readdatavalid),
        .p1_valid         (p1_valid),
        .p1_write         (p1_write),
        .p1_address       (p1_address),
        .p1_byteenable    (p1_byteenable),
        .p1_writedata     (p1_writedata),
        .p1_lock          (p1_lock),
        .p1_ready         (p1_ready),
        .p1_readdata      (p1_readdata),
        .p1_readdatavalid (p1_readdatavalid),
        .mem_chipselect   (mem_chipselect),
        .mem_write        (mem_write),
        .mem_address      (mem_address),
        .mem_byteenable   (mem_byteenable),
        .mem_writedata    (mem_writedata),
        .mem_clken        (mem_clken),
        .mem_readdata     (mem_readdata)
    );

    // Single-port RAM with unregistered output, data valid the cycle after the address
    logic [DATA_W-1:0] ram [1024];
    always @(posedge clk) begin
        if (mem_chipselect && mem_clken) begin
            if (mem_write) begin
                for (int b = 0; b < int'(BE_W); b++)
                    if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
            end else begin
                mem_readdata <= ram[mem_address];
            end
        end
    end

    // Reference model state
    logic [DATA_W-1:0] ref_mem [1024];
    int m_last, m_locked, m_beats, m_pend_id;
    bit m_pend;
    logic [DATA_W-1:0] m_pend_data;

    int n_checks = 0;
    int n_fail   = 0;

    // Observed values of the most recent step
    int s_gnt;
    logic s_rdv0, s_rdv1;
    logic [DATA_W-1:0] s_rd0, s_rd1;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int model_grant();
        bit v0, v1;
        v0 = p0_valid && !reset;
        v1 = p1_valid && !reset;
        if (m_locked == 0 && v0) return 0;
        if (m_locked == 1 && v1) return 1;
        if (v0 && v1) return (m_last == 0) ? 1 : 0;
        if (v0) return 0;
        if (v1) return 1;
        return -1;
    endfunction

    task automatic model_update(input int g);
        logic wr, lk;
        logic [ADDR_W-1:0] addr;
        logic [BE_W-1:0] be;
        logic [DATA_W-1:0] wd;
        m_pend = 1'b0;
        if (reset) begin
            m_last = 1; m_locked = -1; m_beats = 0;
            return;
        end
        if (g < 0) begin
            m_locked = -1; m_beats = 0;
            return;
        end
        wr   = (g == 1) ? p1_write : p0_write;
        lk   = (g == 1) ? p1_lock : p0_lock;
        addr = (g == 1) ? p1_address : p0_address;
        be   = (g == 1) ? p1_byteenable : p0_byteenable;
        wd   = (g == 1) ? p1_writedata : p0_writedata;
        if (wr) begin
            for (int b = 0; b < int'(BE_W); b++)
                if (be[b]) ref_mem[addr][8*b +: 8] = wd[8*b +: 8];
        end else begin
            m_pend = 1'b1; m_pend_id = g; m_pend_data = ref_mem[addr];
        end
        if (m_locked < 0) begin
            if (lk && MAX_LOCK > 1) begin m_locked = g; m_beats = 1; end
        end else if (g == m_locked && lk && (m_beats + 1) < int'(MAX_LOCK)) begin
            m_beats++;
        end else begin
            m_locked = -1; m_beats = 0;
        end
        m_last = g;
    endtask

    // One clock: compare at the falling edge, advance the model at the rising edge
    task automatic step();
        int g;
        @(negedge clk);
        g = model_grant();
        s_gnt  = p0_ready ? 0 : (p1_ready ? 1 : -1);
        s_rdv0 = p0_readdatavalid; s_rdv1 = p1_readdatavalid;
        s_rd0  = p0_readdata;      s_rd1  = p1_readdata;
        check_val("p0_ready", p0_ready, g == 0);
        check_val("p1_ready", p1_ready, g == 1);
        check_val("mem_chipselect", mem_chipselect, g >= 0);
        check_val("mem_clken", mem_clken, 1);
        if (g >= 0) begin
            check_val("mem_write", mem_write, (g == 1) ? p1_write : p0_write);
            check_val("mem_address", mem_address, (g == 1) ? p1_address : p0_address);
        end else begin
            check_val("mem_write_idle", mem_write, 0);
        end
        check_val("p0_rdv", p0_readdatavalid, m_pend && m_pend_id == 0 && !reset);
        check_val("p1_rdv", p1_readdatavalid, m_pend && m_pend_id == 1 && !reset);
        if (m_pend && !reset)
            check_val("readdata", (m_pend_id == 1) ? p1_readdata : p0_readdata, m_pend_data);
        @(posedge clk);
        model_update(g);
        #1;
    endtask

    task automatic set_idle();
        p0_valid = 0; p0_write = 0; p0_lock = 0; p0_address = '0; p0_byteenable = '1;
        p0_writedata = '0;
        p1_valid = 0; p1_write = 0; p1_lock = 0; p1_address = '0; p1_byteenable = '1;
        p1_writedata = '0;
    endtask

    task automatic do_reset();
        set_idle();
        reset = 1;
        step();
        check_val("rst_cs", mem_chipselect, 0);
        step();
        reset = 0;
    endtask

    initial begin
        int seq [7];
        int i;
        m_last = 1; m_locked = -1; m_beats = 0; m_pend = 0; m_pend_id = 0; m_pend_data = '0;
        for (int a = 0; a < 1024; a++) begin
            ram[a] = $urandom;
            ref_mem[a] = ram[a];
        end
        set_idle();
        reset = 1;
        #1;
        do_reset();

        // Simultaneous reads alternate starting with port 0
        p0_valid = 1; p0_address = 10'h010;
        p1_valid = 1; p1_address = 10'h020;
        for (int k = 0; k < 6; k++) begin
            step();
            check_val("rr_alternate", s_gnt, k % 2);
        end

        // Locked burst of six words is cut after MAX_LOCK grants
        do_reset();
        p1_valid = 1; p1_address = 10'h3FF;
        i = 0;
        for (int k = 0; k < 7; k++) begin
            p0_valid = (i < 6); p0_write = 1; p0_lock = (i < 5);
            p0_address = 10'h100 + 10'(i); p0_writedata = 32'hC0DE0000 + i;
            step();
            seq[k] = s_gnt;
            if (s_gnt == 0) i++;
        end
        for (int k = 0; k < 7; k++) check_val("lock_seq", seq[k], (k == 4) ? 1 : 0);
        set_idle();
        for (int k = 0; k < 7; k++) begin
            p0_valid = (k < 6); p0_address = 10'h100 + 10'(k);
            step();
            if (k > 0) check_val("lock_readback", s_rd0, 32'hC0DE0000 + k - 1);
        end

        // Byte-enable merge on port 1
        set_idle();
        p1_valid = 1; p1_write = 1; p1_address = 10'h005; p1_writedata = 32'h11223344;
        step();
        p1_byteenable = 4'b0101; p1_writedata = 32'hAABBCCDD;
        step();
        p1_write = 0;
        step();
        set_idle();
        step();
        check_val("be_merge_valid", s_rdv1, 1);
        check_val("be_merge_data", s_rd1, 32'h11BB33DD);

        // Locked owner going idle hands the cycle to the other port
        do_reset();
        p0_valid = 1; p0_lock = 1; p0_address = 10'h040;
        step();
        check_val("idle_lock_first", s_gnt, 0);
        p0_valid = 0; p1_valid = 1; p1_address = 10'h041;
        step();
        check_val("idle_lock_other", s_gnt, 1);
        p0_valid = 1; p0_lock = 0;
        step();
        check_val("idle_lock_open", s_gnt, 0);

        // Reset straight after an accepted read drops its return
        set_idle();
        p1_valid = 1; p1_address = 10'h077;
        step();
        check_val("rst_read_accept", s_gnt, 1);
        reset = 1;
        step();
        check_val("rst_read_dropped", s_rdv1, 0);
        check_val("rst_ready", s_gnt, -1);
        reset = 0;
        p0_valid = 1; p0_address = 10'h078;
        step();
        check_val("rst_first_tie", s_gnt, 0);

        // Write from port 0 then read from port 1 on the next cycle
        set_idle();
        step();
        p0_valid = 1; p0_write = 1; p0_address = 10'h3FF; p0_writedata = 32'hDEADBEEF;
        step();
        set_idle();
        p1_valid = 1; p1_address = 10'h3FF;
        step();
        set_idle();
        step();
        check_val("interleave_data", s_rd1, 32'hDEADBEEF);

        // Random traffic over a small address window
        for (int k = 0; k < 3000; k++) begin
            reset = ($urandom_range(0, 199) == 0);
            p0_valid = $urandom_range(0, 3) != 0;
            p0_write = $urandom_range(0, 1);
            p0_lock = $urandom_range(0, 2) != 0;
            p0_address = 10'($urandom_range(0, 15));
            p0_byteenable = 4'($urandom);
            p0_writedata = $urandom;
            p1_valid = $urandom_range(0, 3) != 0;
            p1_write = $urandom_range(0, 1);
            p1_lock = $urandom_range(0, 3) == 0;
            p1_address = 10'($urandom_range(0, 15));
            p1_byteenable = 4'($urandom);
            p1_writedata = $urandom;
            step();
        end
        reset = 0;
        set_idle();
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
